alu_result_fifo: RTL
====================

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The module SHALL provide parameter N, default 4, the ALU operand width; result width is N+2.
REQ-002 The module SHALL provide parameter DEPTH, default 4, the entry count; it must be a power of two and at least 2.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the ALU result and select presented this cycle are to be captured.
REQ-006 The module SHALL have port in_sel, input, 3 bits: the ALU opcode that produced in_result.
REQ-007 The module SHALL have port in_result, input, N+2 bits, signed: the ALU output.
REQ-008 The module SHALL have port in_ready, output, 1 bit: high when not full; advisory, because the source does not stall.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-011 The module SHALL have port out_sel, output, 3 bits: the head entry opcode.
REQ-012 The module SHALL have port out_result, output, N+2 bits, signed: the head entry result.
REQ-013 The module SHALL have port count, output, clog2(DEPTH)+1 bits: the number of stored entries.
REQ-014 The module SHALL have port overflow, output, 1 bit: sticky; set when a push was dropped.
REQ-015 The module SHALL have port clr_ovf, input, 1 bit: a synchronous clear of overflow.

Function
REQ-016 Push SHALL occur when in_valid=1 and (count<DEPTH, or a pop occurs the same cycle).
REQ-017 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-018 Entries SHALL be {in_sel, in_result}, stored bit-exact with no sign-extension or truncation, and delivered in FIFO order.
REQ-019 Latency SHALL be 1 cycle: an entry pushed at edge k is visible on out_* with out_valid=1 after edge k; there is no combinational in-to-out path.
REQ-020 out_sel and out_result SHALL be driven from registered/stored state only; their value is don't-care while out_valid=0, but stable while out_valid=1 and out_ready=0.
REQ-021 On simultaneous push and pop, count SHALL remain unchanged, including at count=DEPTH (full) and count=1.
REQ-022 A push and pop in the same cycle at count=0 SHALL be impossible, since out_valid=0; the push alone proceeds.
REQ-023 When in_valid=1, count=DEPTH and no pop occurs, the data SHALL be dropped, the FIFO unchanged, and overflow set at the next edge.
REQ-024 clr_ovf=1 SHALL clear overflow at the next edge; if a drop occurs in that same cycle, the set wins.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from count, not from pointer equality alone.
REQ-026 in_ready SHALL equal (count<DEPTH); out_valid SHALL equal (count>0).

Reset
REQ-027 rst_n=0 SHALL asynchronously force count=0, both pointers to 0, out_valid=0, in_ready=1 and overflow=0.
REQ-028 Storage array contents SHALL NOT be reset; out_sel/out_result SHALL read 0 during reset if driven from a head register.
REQ-029 Reset mid-operation SHALL discard all entries; the first push after release behaves as into an empty FIFO.
REQ-030 Reset deassertion SHALL be synchronized to clk by the integrating level; the block assumes a clean release.

Structure
REQ-031 The shared package alu_pkg SHALL hold the SEL encodings: 0 (x+y)/2, 1 2(x+y), 2 x/2+y, 3 x-y/2, 4 NAND, 5 NOT, 6 NOR, 7 XOR; the default N; and the sel width 3.
REQ-032 One sub-module, alu_fifo_mem, SHALL be used: DEPTH x (N+5) storage with 1 write port and 1 read port, unreset.
REQ-033 Pointer, count and overflow logic SHALL reside in alu_result_fifo.

Verification
REQ-034 The bench SHALL cover: reset, then push (sel=1, result=6'sb001010) with out_ready=0 -> after 1 edge out_valid=1, out_sel=1, out_result=+10, count=1.
REQ-035 The bench SHALL cover: push sel 0..3 with results -3, 5, -8, 7 back-to-back, out_ready=0 -> count=4, in_ready=0; then drain -> order -3, 5, -8, 7, then out_valid=0.
REQ-036 The bench SHALL cover: FIFO full with a fifth push (result=+1) and out_ready=0 -> dropped, overflow=1, count=4; clr_ovf pulse -> overflow=0.
REQ-037 The bench SHALL cover: FIFO full with push (result=-1) and out_ready=1 in the same cycle -> push accepted, count stays 4, overflow stays 0; the new entry exits last.
REQ-038 The bench SHALL cover: streaming push every cycle with out_ready=1 for 10 cycles -> count stays 1, output trails input by 1 cycle, pointers wrap cleanly.
REQ-039 The bench SHALL cover: rst_n asserted mid-clock at count=3 -> count=0, out_valid=0 immediately; the next push reappears with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU definitions: select encodings, select width, default operand width
// Ports: none (package).
package alu_pkg;

    localparam int SEL_W     = 3;
    localparam int N_DEFAULT = 4;

    typedef enum logic [SEL_W-1:0] {
        SEL_AVG          = 3'd0,  // (x+y)/2
        SEL_DBL_SUM      = 3'd1,  // 2(x+y)
        SEL_HALFX_PLUS_Y = 3'd2,  // x/2+y
        SEL_X_MINUS_HALF = 3'd3,  // x-y/2
        SEL_NAND         = 3'd4,
        SEL_NOT          = 3'd5,
        SEL_NOR          = 3'd6,
        SEL_XOR          = 3'd7
    } sel_e;

endpackage

// File: rtl/alu_fifo_mem.sv
// rtl/alu_fifo_mem.sv - unreset DEPTH x W storage, one write port, one asynchronous read port
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from stored contents)
module alu_fifo_mem #(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - FIFO buffering ALU {sel, result} pairs with sticky overflow on dropped pushes
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_sel/in_result - capture request with opcode and signed N+2 bit result
//   in_ready             - not full (advisory; source never stalls)
//   out_valid/out_ready  - head entry handshake
//   out_sel/out_result   - head entry contents
//   count                - number of stored entries
//   overflow/clr_ovf     - sticky drop flag and its synchronous clear
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = 4,           // power of two, >= 2
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1,
    localparam int W    = SEL_W + N + 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic signed [N+1:0] in_result,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SEL_W-1:0]    out_sel,
    output logic signed [N+1:0] out_result,
    output logic [CW-1:0]       count,
    output logic                overflow,
    input  logic                clr_ovf
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    logic [W-1:0]  rd_data;

    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when the head is consumed at the same edge.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (in_ready || pop);
    assign drop = in_valid && !push;

    alu_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_sel, in_result}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign out_sel    = rd_data[W-1 -: SEL_W];
    assign out_result = rd_data[N+1:0];

    // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear takes priority so no loss goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
